// File: rtl/tpu_mmio_host_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tpu_mmio_host_if                                              |
// | Description : Job control, operand/result streams and TPU MMIO bus.         |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
interface tpu_mmio_host_if #(
    parameter int ADDRW = 16,
    parameter int DATAW = 64
);
    logic             start;
    logic             busy;
    logic             done;
    logic [DATAW-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [DATAW-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             mm_r_w;
    logic [ADDRW-1:0] mm_addr;
    logic [DATAW-1:0] mm_wdata;
    logic [DATAW-1:0] mm_rdata;

    // master is the sequencer; slave is the surrounding glue plus TPU
    modport master (
        input  start, in_data, in_valid, out_ready, mm_rdata,
        output busy, done, in_ready, out_data, out_valid, mm_r_w, mm_addr, mm_wdata
    );

    modport slave (
        output start, in_data, in_valid, out_ready, mm_rdata,
        input  busy, done, in_ready, out_data, out_valid, mm_r_w, mm_addr, mm_wdata
    );
endinterface
`default_nettype wire

// File: rtl/tpu_mmio_host.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tpu_mmio_host                                                 |
// | Description : Sequences one A/B/C load, MatMul trigger and C readback job.  |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
module tpu_mmio_host #(
    parameter int DIM         = 8,
    parameter int ADDRW       = 16,
    parameter int DATAW       = 64,
    parameter int WAIT_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst,
    tpu_mmio_host_if.master bus
);
    localparam int WW = $clog2(WAIT_CYCLES) + 1;

    localparam logic [ADDRW-1:0] c_base_a  = ADDRW'(16'h0100);
    localparam logic [ADDRW-1:0] c_base_b  = ADDRW'(16'h0200);
    localparam logic [ADDRW-1:0] c_base_c  = ADDRW'(16'h0300);
    localparam logic [ADDRW-1:0] c_addr_mm = ADDRW'(16'h0400);
    localparam logic [4:0]       c_last_ab = 5'(DIM - 1);
    localparam logic [4:0]       c_last_c  = 5'(2 * DIM - 1);
    localparam logic [3:0]       c_last_rd = 4'(2 * DIM - 1);
    localparam logic [WW-1:0]    c_wait_last = WW'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_A   = 3'd1,
        S_LOAD_B   = 3'd2,
        S_LOAD_C   = 3'd3,
        S_TRIG     = 3'd4,
        S_WAIT     = 3'd5,
        S_RD_ISSUE = 3'd6,
        S_RD_HOLD  = 3'd7
    } state_t;

    state_t           r_state,    w_state;
    logic [4:0]       r_cnt,      w_cnt;
    logic [3:0]       r_rd_idx,   w_rd_idx;
    logic [WW-1:0]    r_wait_cnt, w_wait_cnt;
    logic             r_mm_r_w,   w_mm_r_w;
    logic [ADDRW-1:0] r_mm_addr,  w_mm_addr;
    logic [DATAW-1:0] r_mm_wdata, w_mm_wdata;
    logic [DATAW-1:0] r_out_data, w_out_data;
    logic             r_out_valid, w_out_valid;
    logic             r_done,     w_done;

    logic             w_in_ready;
    logic             w_hs;
    logic [ADDRW-1:0] w_load_base;
    logic [4:0]       w_load_last;
    state_t           w_load_next;
    logic [3:0]       w_rd_next;

    assign w_in_ready = (r_state == S_LOAD_A) || (r_state == S_LOAD_B) || (r_state == S_LOAD_C);
    assign w_hs       = bus.in_valid && w_in_ready;
    assign w_rd_next  = r_rd_idx + 4'd1;

    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.mm_r_w    = r_mm_r_w;
    assign bus.mm_addr   = r_mm_addr;
    assign bus.mm_wdata  = r_mm_wdata;

    always_comb begin
        w_load_base = c_base_a;
        w_load_last = c_last_ab;
        w_load_next = S_LOAD_B;
        case (r_state)
            S_LOAD_B: begin
                w_load_base = c_base_b;
                w_load_next = S_LOAD_C;
            end
            S_LOAD_C: begin
                w_load_base = c_base_c;
                w_load_last = c_last_c;
                w_load_next = S_TRIG;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_rd_idx    = r_rd_idx;
        w_wait_cnt  = r_wait_cnt;
        w_mm_r_w    = 1'b0;
        w_mm_addr   = '0;
        w_mm_wdata  = '0;
        w_out_data  = r_out_data;
        w_out_valid = r_out_valid;
        w_done      = 1'b0;

        case (r_state)
            S_IDLE: begin
                // The done cycle already sits in IDLE, so a start there is dropped
                if (bus.start && !r_done) begin
                    w_state    = S_LOAD_A;
                    w_cnt      = '0;
                    w_rd_idx   = '0;
                    w_wait_cnt = '0;
                end
            end
            S_LOAD_A, S_LOAD_B, S_LOAD_C: begin
                if (w_hs) begin
                    w_mm_r_w   = 1'b1;
                    w_mm_addr  = w_load_base + ADDRW'({r_cnt, 3'b000});
                    w_mm_wdata = bus.in_data;
                    if (r_cnt == w_load_last) begin
                        w_state = w_load_next;
                        w_cnt   = '0;
                    end else begin
                        w_cnt = r_cnt + 5'd1;
                    end
                end
            end
            S_TRIG: begin
                w_mm_addr  = c_addr_mm;
                w_state    = S_WAIT;
                w_wait_cnt = '0;
            end
            S_WAIT: begin
                if (r_wait_cnt == c_wait_last) begin
                    w_state   = S_RD_ISSUE;
                    w_rd_idx  = '0;
                    w_mm_addr = c_base_c;
                end else begin
                    w_wait_cnt = r_wait_cnt + WW'(1);
                end
            end
            S_RD_ISSUE: begin
                // mm_rdata is combinational in the address already on the bus
                w_mm_addr   = r_mm_addr;
                w_out_data  = bus.mm_rdata;
                w_out_valid = 1'b1;
                w_state     = S_RD_HOLD;
            end
            S_RD_HOLD: begin
                w_mm_addr = r_mm_addr;
                if (r_out_valid && bus.out_ready) begin
                    w_out_valid = 1'b0;
                    if (r_rd_idx == c_last_rd) begin
                        w_done    = 1'b1;
                        w_rd_idx  = '0;
                        w_mm_addr = '0;
                        w_state   = S_IDLE;
                    end else begin
                        w_rd_idx  = w_rd_next;
                        w_mm_addr = c_base_c + ADDRW'({w_rd_next, 3'b000});
                        w_state   = S_RD_ISSUE;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rd_idx    <= '0;
            r_wait_cnt  <= '0;
            r_mm_r_w    <= 1'b0;
            r_mm_addr   <= '0;
            r_mm_wdata  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_rd_idx    <= w_rd_idx;
            r_wait_cnt  <= w_wait_cnt;
            r_mm_r_w    <= w_mm_r_w;
            r_mm_addr   <= w_mm_addr;
            r_mm_wdata  <= w_mm_wdata;
            r_out_data  <= w_out_data;
            r_out_valid <= w_out_valid;
            r_done      <= w_done;
        end
    end
endmodule
`default_nettype wire
